// File: rtl/axi_pkg.sv
// Shared AXI encodings and helpers for the read (and future write) responders.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;

    // log2 of the bytes per data word; data_w is a power of two >= 8
    function automatic int beat_bytes_log2(input int data_w);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((8 << i) == data_w) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AXI4 read address and read data channels between an initiator and a responder.
interface axi_read_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport slave (
        input  ARVALID, ARADDR, ARPROT, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST
    );

    modport master (
        output ARVALID, ARADDR, ARPROT, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] sz;
    logic [ADDR_W-1:0] wmask;

    always_comb begin
        sz        = ADDR_W'(1) << size;
        wmask     = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = (addr & ~(sz - ADDR_W'(1))) + sz;
            // stay inside the (len+1)*sz aligned window
            BURST_WRAP: next_addr = (addr & ~wmask) | ((addr + sz) & wmask);
            default:    next_addr = addr;
        endcase
    end
endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read responder backed by an inferred synchronous-read SRAM with a backdoor load port.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 256,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_read_responder_if.slave   axi,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [DATA_W-1:0]     ld_data
);
    localparam int BL    = beat_bytes_log2(DATA_W);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt, rd_addr, rd_off;
    logic [7:0]        len_q, beat_cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q, oor_q, err_in, oor_in;
    logic              ar_hs, r_hs, last, rd_en, bad;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [2:0]        unused_prot;

    assign unused_prot = axi.ARPROT;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_next (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_comb begin
        err_in = (int'(axi.ARSIZE) > BL) || (axi.ARBURST == 2'b11);
        if (axi.ARBURST == BURST_WRAP) begin
            if (!(axi.ARLEN == 8'd1 || axi.ARLEN == 8'd3 ||
                  axi.ARLEN == 8'd7 || axi.ARLEN == 8'd15)) err_in = 1'b1;
            if ((axi.ARADDR & ((ADDR_W'(1) << axi.ARSIZE) - ADDR_W'(1))) != '0) err_in = 1'b1;
        end
    end

    assign ar_hs   = (state == IDLE) && axi.ARVALID;
    assign last    = (beat_cnt == len_q);
    assign r_hs    = (state == SEND) && axi.RREADY;
    // the next beat's read is issued in the same cycle its predecessor is accepted
    assign rd_en   = (state == FETCH) || (r_hs && !last);
    assign rd_addr = (state == FETCH) ? addr_q : addr_nxt;
    assign rd_off  = rd_addr - BASE;
    assign rd_idx  = rd_off[BL +: DEPTH_LOG2];
    assign oor_in  = (rd_off >> (BL + DEPTH_LOG2)) != '0;
    assign bad     = err_q || oor_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = RESP_OKAY;
        axi.RDATA   = '0;
        case (state)
            IDLE: begin
                axi.ARREADY = ARESETn;
                if (axi.ARVALID) state_nxt = FETCH;
            end
            FETCH: state_nxt = SEND;
            SEND: begin
                axi.RVALID = ARESETn;
                axi.RLAST  = ARESETn && last;
                axi.RRESP  = (ARESETn && bad) ? RESP_SLVERR : RESP_OKAY;
                axi.RDATA  = (ARESETn && !bad) ? rd_q : '0;
                if (axi.RREADY && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            if (ar_hs) begin
                beat_cnt <= 8'd0;
                err_q    <= err_in;
            end else if (r_hs && !last) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (rd_en) oor_q <= oor_in;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            addr_q  <= axi.ARADDR;
            len_q   <= axi.ARLEN;
            size_q  <= axi.ARSIZE;
            burst_q <= axi.ARBURST;
        end else if (r_hs && !last) begin
            addr_q  <= addr_nxt;
        end
    end

    // read-before-write: a same-cycle load to the read index returns the old word
    always_ff @(posedge ACLK) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        if (rd_en) rd_q <= mem[rd_idx];
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: bursts, backpressure, errors and mid-burst reset.
module tb_axi_read_responder;
    import axi_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic         ld_en = 1'b0;
    logic [9:0]   ld_idx = '0;
    logic [255:0] ld_data = '0;

    axi_read_responder_if #(.ADDR_W(32), .DATA_W(256)) axi ();

    axi_read_responder #(
        .ADDR_W(32), .DATA_W(256), .DEPTH_LOG2(10), .BASE(BASE)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .axi     (axi),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
    );

    always #5 ACLK = ~ACLK;

    beat_t        sb[$];
    beat_t        mon_e;
    beat_t        held;
    logic [255:0] shadow [1024];
    int           n_chk = 0;
    int           n_fail = 0;
    int           hs_cnt = 0;
    bit           mon_en = 1'b1;
    bit           hold_v = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge ACLK) begin
        if (hold_v && axi.RVALID) begin
            chk("hold_data", axi.RDATA, held.data);
            chk("hold_resp", 256'(axi.RRESP), 256'(held.resp));
            chk("hold_last", 256'(axi.RLAST), 256'(held.last));
        end
        hold_v = 1'b0;
        if (axi.RVALID && !axi.RREADY) begin
            hold_v    = 1'b1;
            held.data = axi.RDATA;
            held.resp = axi.RRESP;
            held.last = axi.RLAST;
        end
        if (axi.RVALID && axi.RREADY) begin
            hs_cnt++;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 256'(1), 256'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("rdata", axi.RDATA, mon_e.data);
                    chk("rresp", 256'(axi.RRESP), 256'(mon_e.resp));
                    chk("rlast", 256'(axi.RLAST), 256'(mon_e.last));
                end
            end
        end
    end

    function automatic logic [31:0] model_next(input logic [31:0] a, input int len,
                                               input int size, input logic [1:0] burst);
        logic [31:0] sz, total, wbase;
        sz    = 32'd1 << size;
        total = 32'(len + 1) * sz;
        case (burst)
            BURST_INCR: return a - (a % sz) + sz;
            BURST_WRAP: begin
                wbase = a - (a % total);
                return wbase + ((a - wbase + sz) % total);
            end
            default: return a;
        endcase
    endfunction

    task automatic push_expected(input logic [31:0] addr, input int len, input int size,
                                 input logic [1:0] burst);
        logic [31:0] a, off, sz;
        bit          err, oor;
        beat_t       e;
        sz  = 32'd1 << size;
        err = (size > 5) || (burst == 2'b11) ||
              (burst == BURST_WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == BURST_WRAP && (addr % sz) != 0);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            off    = a - BASE;
            oor    = off >= 32'(1024 * 32);
            e.data = (err || oor) ? 256'd0 : shadow[off[14:5]];
            e.resp = (err || oor) ? RESP_SLVERR : RESP_OKAY;
            e.last = (i == len);
            sb.push_back(e);
            a = model_next(a, len, size, burst);
        end
    endtask

    task automatic load(input int idx, input logic [255:0] d);
        ld_en   = 1'b1;
        ld_idx  = 10'(idx);
        ld_data = d;
        shadow[idx] = d;
        @(posedge ACLK); #1;
        ld_en = 1'b0;
    endtask

    task automatic wait_arready();
        int cyc;
        cyc = 0;
        while (!axi.ARREADY && cyc < 50) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        if (cyc >= 50) chk("arready_timeout", 256'(0), 256'(1));
    endtask

    task automatic send_ar(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst);
        axi.ARVALID = 1'b1;
        axi.ARADDR  = addr;
        axi.ARLEN   = 8'(len);
        axi.ARSIZE  = 3'(size);
        axi.ARBURST = burst;
        @(posedge ACLK); #1;
        axi.ARVALID = 1'b0;
    endtask

    task automatic burst(input logic [31:0] addr, input int len, input int size,
                         input logic [1:0] burst_t, input int stall_beat, input int stall_n);
        int cyc, hs0, stall_left;
        wait_arready();
        push_expected(addr, len, size, burst_t);
        axi.RREADY = 1'b1;
        hs0 = hs_cnt;
        send_ar(addr, len, size, burst_t);
        chk("fetch_rvalid", 256'(axi.RVALID), 256'(0));
        chk("fetch_arready", 256'(axi.ARREADY), 256'(0));
        @(posedge ACLK); #1;
        chk("first_rvalid", 256'(axi.RVALID), 256'(1));
        cyc = 0;
        stall_left = stall_n;
        while (sb.size() != 0 && cyc < 300) begin
            if (axi.RVALID && (hs_cnt - hs0) == stall_beat && stall_left > 0) begin
                axi.RREADY = 1'b0;
                stall_left--;
            end else begin
                axi.RREADY = 1'b1;
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        if (cyc >= 300) begin
            chk("drain_timeout", 256'(sb.size()), 256'(0));
            sb.delete();
        end
        axi.RREADY = 1'b1;
        chk("post_arready", 256'(axi.ARREADY), 256'(1));
        chk("post_rvalid", 256'(axi.RVALID), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hs0;
        axi.ARVALID = 1'b0;
        axi.ARADDR  = '0;
        axi.ARPROT  = 3'b000;
        axi.ARLEN   = '0;
        axi.ARSIZE  = '0;
        axi.ARBURST = '0;
        axi.RREADY  = 1'b1;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", 256'(axi.ARREADY), 256'(0));
        chk("rst_rvalid", 256'(axi.RVALID), 256'(0));
        chk("rst_rlast", 256'(axi.RLAST), 256'(0));
        chk("rst_rresp", 256'(axi.RRESP), 256'(0));
        chk("rst_rdata", axi.RDATA, 256'(0));
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("rst_exit_arready", 256'(axi.ARREADY), 256'(1));

        load(4, {32{8'hA5}});
        for (int i = 0; i < 4; i++) load(i, 256'(i + 1));
        load(1023, {8{32'hDEAD_BEEF}});

        burst(BASE + 32'h80, 0, 5, BURST_INCR, -1, 0);
        burst(BASE, 3, 5, BURST_INCR, 1, 3);
        burst(BASE + 32'h40, 3, 5, BURST_WRAP, -1, 0);
        burst(BASE + 32'h24, 2, 2, BURST_FIXED, -1, 0);
        burst(BASE + 32'h1E, 3, 2, BURST_INCR, 2, 2);
        burst(BASE, 1, 5, 2'b11, -1, 0);
        burst(BASE + 32'(1023 * 32), 1, 5, BURST_INCR, -1, 0);
        burst(BASE - 32'd32, 0, 5, BURST_INCR, -1, 0);
        burst(BASE, 0, 6, BURST_INCR, -1, 0);
        burst(BASE, 2, 5, BURST_WRAP, -1, 0);

        // abandon a len=7 burst after its third beat
        wait_arready();
        mon_en = 1'b0;
        hs0 = hs_cnt;
        send_ar(BASE, 7, 5, BURST_INCR);
        cyc = 0;
        while ((hs_cnt - hs0) < 3 && cyc < 50) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        if (cyc >= 50) chk("midburst_timeout", 256'(hs_cnt - hs0), 256'(3));
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_rvalid", 256'(axi.RVALID), 256'(0));
        chk("mid_rst_arready", 256'(axi.ARREADY), 256'(0));
        chk("mid_rst_rdata", axi.RDATA, 256'(0));
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        #1;
        chk("after_rst_arready", 256'(axi.ARREADY), 256'(1));
        chk("after_rst_rvalid", 256'(axi.RVALID), 256'(0));
        mon_en = 1'b1;
        burst(BASE + 32'h80, 0, 5, BURST_INCR, -1, 0);

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
